// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: paces moles with a prescaled tick counter, picks holes
// from an 8-bit LFSR, and reports hits and timeouts as one-cycle pulses.
module mole_scheduler #(
  parameter int unsigned TICK_DIV  = 25000,
  parameter int unsigned GAP_TICKS = 300,
  parameter int unsigned LIFE0     = 1000,
  parameter int unsigned LIFE1     = 800,
  parameter int unsigned LIFE2     = 600,
  parameter int unsigned LIFE3     = 400,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] level,
  input  logic       hit,
  input  logic [3:0] hit_index,
  output logic       mole_appear,
  output logic [3:0] mole_index,
  output logic       hit_success,
  output logic       miss
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [11:0]   GAP_LOAD  = 12'(GAP_TICKS);
  localparam logic [7:0]    LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SPAWN, S_UP} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [11:0]   r_count;
  logic [7:0]    r_lfsr;
  logic [3:0]    r_mole_index;
  logic          r_mole_appear;
  logic          r_hit_success;
  logic          r_miss;

  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [11:0]   w_count_nxt;
  logic [11:0]   w_life;
  logic [3:0]    w_cand;
  logic [3:0]    w_cand_adj;
  logic [3:0]    w_index_nxt;
  logic          w_tick;
  logic          w_expire;
  logic          w_hit_ok;
  logic          w_lfsr_fb;
  logic          w_appear_nxt;
  logic          w_hit_nxt;
  logic          w_miss_nxt;

  assign w_tick     = (r_presc == TICK_LAST);
  // A phase ends on the tick that would take the counter from 1 to 0.
  assign w_expire   = w_tick && (r_count <= 12'd1);
  assign w_hit_ok   = (r_state == S_UP) && hit && (hit_index == r_mole_index);
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cand     = r_lfsr[3:0];
  assign w_cand_adj = (w_cand == r_mole_index) ? w_cand + 4'd1 : w_cand;

  always_comb begin
    case (level)
      2'd0:    w_life = 12'(LIFE0);
      2'd1:    w_life = 12'(LIFE1);
      2'd2:    w_life = 12'(LIFE2);
      default: w_life = 12'(LIFE3);
    endcase
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_GAP;
        S_GAP:   if (w_expire) w_state_nxt = S_SPAWN;
        S_SPAWN: w_state_nxt = S_UP;
        S_UP:    if (w_hit_ok || w_expire) w_state_nxt = S_GAP;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_appear_nxt = (w_state_nxt == S_UP);
    w_hit_nxt    = enable && w_hit_ok;
    w_miss_nxt   = enable && (r_state == S_UP) && w_expire && !w_hit_ok;
    w_index_nxt  = r_mole_index;
    if (enable && (r_state == S_SPAWN)) w_index_nxt = w_cand_adj;
  end

  // Level is captured only by the counter load on SPAWN->UP.
  always_comb begin
    w_presc_nxt = (r_presc == TICK_LAST) ? '0 : r_presc + PW'(1);
    w_count_nxt = (w_tick && (r_count != 12'd0)) ? r_count - 12'd1 : r_count;
    if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) begin
      w_presc_nxt = '0;
      case (w_state_nxt)
        S_GAP:   w_count_nxt = GAP_LOAD;
        S_UP:    w_count_nxt = w_life;
        default: w_count_nxt = 12'd0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_count       <= 12'd0;
      r_lfsr        <= LFSR_INIT;
      r_mole_index  <= 4'd0;
      r_mole_appear <= 1'b0;
      r_hit_success <= 1'b0;
      r_miss        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_presc       <= w_presc_nxt;
      r_count       <= w_count_nxt;
      r_lfsr        <= {r_lfsr[6:0], w_lfsr_fb};
      r_mole_index  <= w_index_nxt;
      r_mole_appear <= w_appear_nxt;
      r_hit_success <= w_hit_nxt;
      r_miss        <= w_miss_nxt;
    end
  end

  assign mole_appear = r_mole_appear;
  assign mole_index  = r_mole_index;
  assign hit_success = r_hit_success;
  assign miss        = r_miss;

endmodule
